pixel_read_arbiter: RTL and testbench

- Shares the single SDRAM burst-read port between up to NREQ point-request clients: rough finder, precision finder, flag finder and decoder.
- Latches each client's point request and its (x,y) coordinate, then grants round-robin.
- Forms the linear SDRAM address, issues one burst read, thresholds the returned pixel to one bit, and returns it to the granted client.
- Replaces per-state request muxing with a queued, fair scheduler; sits between the finder blocks and the SDRAM read controller.

---
 rtl/pixel_read_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pixel_read_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst-read port among NREQ point-request clients.
// Optional macro PIXREQ_TIMEOUT_EN adds a REQ-state watchdog that forces a zero answer.
module pixel_read_arbiter #(
    parameter int NREQ     = 4,
    parameter int IMG_W    = 640,
    parameter int ADDR_OFS = 4,
    parameter int THRESH   = 400,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*10-1:0] req_x,
    input  logic [NREQ*10-1:0] req_y,
    output logic [NREQ-1:0]    ans_valid,
    output logic               ans_bit,
    output logic               rd_burst_req,
    output logic [23:0]        rd_burst_addr,
    input  logic [15:0]        rd_burst_data,
    input  logic               rd_burst_data_valid,
    input  logic               rd_burst_finish,
    output logic               busy,
    output logic               err_timeout,
    output logic [1:0]         dbg_state
);

    // Handshakes: req is a one-cycle pulse with no backpressure (a pulse on an
    // already pending client is dropped); rd_burst_req is a level held until
    // rd_burst_finish is seen; ans_valid is a one-cycle pulse with no ready.

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] THRESH_W = 16'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_REQ  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state;
    logic [NREQ-1:0] pending;
    logic [9:0]      cx [NREQ];
    logic [9:0]      cy [NREQ];
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   pick;
    logic            pick_found;
    logic            cap_bit;
    logic            cap_seen;
    logic [NREQ-1:0] clr_mask;
    logic [NREQ-1:0] gnt_onehot;
    logic [IW-1:0]   rr_next;
    logic [23:0]     addr_calc;
    int              idx;

    // First pending client at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!pick_found && pending[IW'(idx)]) begin
                pick_found = 1'b1;
                pick       = IW'(idx);
            end
        end
    end

    always_comb begin
        gnt_onehot = NREQ'(1) << gnt;
        clr_mask   = (state == S_RESP) ? gnt_onehot : '0;
        rr_next    = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        addr_calc  = 24'(cy[gnt]) * 24'(IMG_W) + 24'(cx[gnt]) + 24'(ADDR_OFS);
    end

    assign busy      = (state != S_IDLE) || (|pending);
    assign dbg_state = state;

`ifdef PIXREQ_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] to_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            gnt           <= '0;
            cap_bit       <= 1'b0;
            cap_seen      <= 1'b0;
            ans_valid     <= '0;
            ans_bit       <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cx[i] <= '0;
                cy[i] <= '0;
            end
`ifdef PIXREQ_TIMEOUT_EN
            to_cnt        <= '0;
            err_timeout   <= 1'b0;
`endif
        end else begin
            ans_valid <= '0;
            ans_bit   <= 1'b0;
`ifdef PIXREQ_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif

            // A new pulse in the clearing cycle re-arms the client with fresh coords.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (!pending[i] || clr_mask[i])) begin
                    pending[i] <= 1'b1;
                    cx[i]      <= req_x[10*i +: 10];
                    cy[i]      <= req_y[10*i +: 10];
                end else if (clr_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick;
                        state <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    rd_burst_addr <= addr_calc;
                    cap_seen      <= 1'b0;
                    cap_bit       <= 1'b0;
                    rd_burst_req  <= 1'b1;
`ifdef PIXREQ_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                    state         <= S_REQ;
                end

                S_REQ: begin
                    if (rd_burst_data_valid && !cap_seen) begin
                        cap_seen <= 1'b1;
                        cap_bit  <= (rd_burst_data < THRESH_W);
                    end
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        state        <= S_RESP;
                    end
`ifdef PIXREQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rd_burst_req <= 1'b0;
                        err_timeout  <= 1'b1;
                        cap_bit      <= 1'b0;
                        state        <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 10'd1;
                    end
`endif
                end

                S_RESP: begin
                    ans_valid <= gnt_onehot;
                    ans_bit   <= cap_bit;
                    rr_ptr    <= rr_next;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Testbench for pixel_read_arbiter: SDRAM-side driver, answer scoreboard and per-scenario tasks.
module tb_pixel_read_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*10-1:0] req_x = '0;
    logic [NREQ*10-1:0] req_y = '0;
    logic [NREQ-1:0]    ans_valid;
    logic               ans_bit;
    logic               rd_burst_req;
    logic [23:0]        rd_burst_addr;
    logic [15:0]        rd_burst_data = '0;
    logic               rd_burst_data_valid = 1'b0;
    logic               rd_burst_finish = 1'b0;
    logic               busy;
    logic               err_timeout;
    logic [1:0]         dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    pixel_read_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .ans_valid(ans_valid), .ans_bit(ans_bit), .rd_burst_req(rd_burst_req),
        .rd_burst_addr(rd_burst_addr), .rd_burst_data(rd_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // Scoreboard: every answer pulse must match the oldest expected {ans_valid, ans_bit}.
    always @(posedge clk) begin
        logic [4:0] want;
        #1;
        if (ans_valid !== '0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL answer_unexpected: got ans_valid=%b ans_bit=%b, required no answer", ans_valid, ans_bit);
            end else begin
                want = exp_q.pop_front();
                if ({ans_valid, ans_bit} !== want) begin
                    tests_failed++;
                    $display("FAIL answer: got ans_valid=%b ans_bit=%b, required ans_valid=%b ans_bit=%b",
                             ans_valid, ans_bit, want[4:1], want[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_coord(input int c, input logic [9:0] x, input logic [9:0] y);
        req_x[10*c +: 10] = x;
        req_y[10*c +: 10] = y;
    endtask

    task automatic pulse_mask(input logic [NREQ-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic push_exp(input int c, input logic b);
        logic [3:0] oh;
        oh = 4'b0001 << c;
        exp_q.push_back({oh, b});
    endtask

    // Plays the SDRAM controller: waits for rd_burst_req, streams words, pulses finish.
    // Returns at 1 ns after the edge that sampled finish.
    task automatic sdram_burst(input int nwords, input logic [15:0] d0, input logic [15:0] drest,
                               input bit fin_with_last, output logic [23:0] addr_seen, output bit ok);
        ok = 1'b0;
        addr_seen = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rd_burst_req === 1'b1) ok = 1'b1;
            else tick();
        end
        if (!ok) return;
        addr_seen = rd_burst_addr;
        for (int k = 0; k < nwords; k++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data = (k == 0) ? d0 : drest;
            if (fin_with_last && k == nwords - 1) rd_burst_finish = 1'b1;
            tick();
        end
        rd_burst_data_valid = 1'b0;
        rd_burst_data = '0;
        if (!(fin_with_last && nwords > 0)) begin
            rd_burst_finish = 1'b1;
            tick();
        end
        rd_burst_finish = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (ans_valid !== 4'b0000 || ans_bit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ans: got ans_valid=%b ans_bit=%b, required 0000/0", ans_valid, ans_bit);
        end
        tests_run++;
        if (rd_burst_req !== 1'b0 || rd_burst_addr !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_rd: got req=%b addr=%0d, required 0/0", rd_burst_req, rd_burst_addr);
        end
        tests_run++;
        if (busy !== 1'b0 || err_timeout !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_status: got busy=%b err=%b state=%0d, required 0/0/0", busy, err_timeout, dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [23:0] a;
        bit ok;
        push_exp(1, 1'b1);
        set_coord(1, 10'd10, 10'd2);
        pulse_mask(4'b0010);
        tests_run++;
        if (busy !== 1'b1 || rd_burst_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_capture: got busy=%b req=%b, required 1/0", busy, rd_burst_req);
        end
        tick();
        tests_run++;
        if (rd_burst_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early_req: got %b, required 0", rd_burst_req);
        end
        tick();
        tests_run++;
        if (rd_burst_req !== 1'b1 || rd_burst_addr !== 24'd1294) begin
            tests_failed++;
            $display("FAIL basic_latency: got req=%b addr=%0d, required 1/1294", rd_burst_req, rd_burst_addr);
        end
        sdram_burst(1, 16'd399, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || rd_burst_req !== 1'b0 || ans_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic_finish: got ok=%b req=%b ans_valid=%b, required 1/0/0000", ok, rd_burst_req, ans_valid);
        end
        tick();
        tests_run++;
        if (ans_valid !== 4'b0010 || ans_bit !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_answer: got %b/%b, required 0010/1", ans_valid, ans_bit);
        end
        tick();
        tests_run++;
        if (ans_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic_one_cycle: got %b, required 0000", ans_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] a;
        bit ok;
        apply_reset();
        push_exp(0, 1'b0);
        push_exp(2, 1'b0);
        set_coord(0, 10'd1, 10'd0);
        set_coord(2, 10'd3, 10'd1);
        pulse_mask(4'b0101);
        sdram_burst(1, 16'd400, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd5) begin
            tests_failed++;
            $display("FAIL rr_first: got ok=%b addr=%0d, required 1/5", ok, a);
        end
        tick();
        sdram_burst(1, 16'd400, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd647) begin
            tests_failed++;
            $display("FAIL rr_second: got ok=%b addr=%0d, required 1/647", ok, a);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_idle_busy: got %b, required 0", busy);
        end
        // Pointer now sits at 3, so client 3 beats client 1.
        push_exp(3, 1'b1);
        push_exp(1, 1'b0);
        set_coord(3, 10'd9, 10'd0);
        set_coord(1, 10'd2, 10'd1);
        pulse_mask(4'b1010);
        sdram_burst(1, 16'd0, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd13) begin
            tests_failed++;
            $display("FAIL rr_ptr3: got ok=%b addr=%0d, required 1/13", ok, a);
        end
        tick();
        sdram_burst(1, 16'd1000, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd646) begin
            tests_failed++;
            $display("FAIL rr_wrap: got ok=%b addr=%0d, required 1/646", ok, a);
        end
        tick();
    endtask

    task automatic test_repulse();
        logic [23:0] a;
        bit ok;
        push_exp(3, 1'b1);
        set_coord(3, 10'd7, 10'd1);
        pulse_mask(4'b1000);
        set_coord(3, 10'd5, 10'd5);
        pulse_mask(4'b1000);
        sdram_burst(1, 16'd100, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd651) begin
            tests_failed++;
            $display("FAIL repulse_addr: got ok=%b addr=%0d, required 1/651", ok, a);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL repulse_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_data_corners();
        logic [23:0] a;
        bit ok;
        push_exp(0, 1'b0);
        set_coord(0, 10'd0, 10'd0);
        pulse_mask(4'b0001);
        sdram_burst(0, 16'd0, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd4) begin
            tests_failed++;
            $display("FAIL nodata_addr: got ok=%b addr=%0d, required 1/4", ok, a);
        end
        tick();
        push_exp(1, 1'b1);
        set_coord(1, 10'd639, 10'd0);
        pulse_mask(4'b0010);
        sdram_burst(1, 16'd399, 16'd0, 1'b1, a, ok);
        tests_run++;
        if (!ok || a !== 24'd643) begin
            tests_failed++;
            $display("FAIL samecycle_addr: got ok=%b addr=%0d, required 1/643", ok, a);
        end
        tick();
        push_exp(2, 1'b0);
        set_coord(2, 10'd1023, 10'd1023);
        pulse_mask(4'b0100);
        sdram_burst(3, 16'd400, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd655747) begin
            tests_failed++;
            $display("FAIL maxcoord_addr: got ok=%b addr=%0d, required 1/655747", ok, a);
        end
        tick();
    endtask

    task automatic test_stray();
        rd_burst_finish = 1'b1;
        rd_burst_data_valid = 1'b1;
        rd_burst_data = 16'd1;
        tick();
        rd_burst_finish = 1'b0;
        rd_burst_data_valid = 1'b0;
        tests_run++;
        if (dbg_state !== 2'd0 || rd_burst_req !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_finish: got state=%0d req=%b busy=%b err=%b, required 0/0/0/0",
                     dbg_state, rd_burst_req, busy, err_timeout);
        end
        tick();
        tests_run++;
        if (ans_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL stray_answer: got %b, required 0000", ans_valid);
        end
    endtask

    task automatic test_set_wins();
        logic [23:0] a;
        bit ok;
        push_exp(2, 1'b1);
        set_coord(2, 10'd4, 10'd0);
        pulse_mask(4'b0100);
        sdram_burst(1, 16'd10, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd8) begin
            tests_failed++;
            $display("FAIL setwins_first: got ok=%b addr=%0d, required 1/8", ok, a);
        end
        set_coord(2, 10'd6, 10'd0);
        pulse_mask(4'b0100);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL setwins_pending: got busy=%b, required 1", busy);
        end
        push_exp(2, 1'b0);
        sdram_burst(1, 16'd900, 16'd0, 1'b0, a, ok);
        tests_run++;
        if (!ok || a !== 24'd10) begin
            tests_failed++;
            $display("FAIL setwins_second: got ok=%b addr=%0d, required 1/10", ok, a);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_coord(1, 10'd0, 10'd0);
        pulse_mask(4'b0010);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (rd_burst_req === 1'b1) ok = 1'b1;
            else tick();
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL resetmid_wait: got no rd_burst_req, required 1 within 10 cycles");
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (rd_burst_req !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL resetmid_drop: got req=%b busy=%b, required 0/0", rd_burst_req, busy);
        end
        reset = 1'b0;
        rd_burst_finish = 1'b1;
        rd_burst_data_valid = 1'b1;
        tick();
        rd_burst_finish = 1'b0;
        rd_burst_data_valid = 1'b0;
        tick();
        tests_run++;
        if (ans_valid !== 4'b0000 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL resetmid_late_finish: got ans=%b busy=%b state=%0d, required 0000/0/0",
                     ans_valid, busy, dbg_state);
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [23:0] exp_addr;
        bit ok;
        int c, x, y, d;
        for (int n = 0; n < 8; n++) begin
            c = $urandom_range(0, NREQ - 1);
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            d = $urandom_range(380, 420);
            exp_addr = 24'(y * 640 + x + 4);
            push_exp(c, (d < 400));
            set_coord(c, 10'(x), 10'(y));
            pulse_mask(4'b0001 << c);
            sdram_burst($urandom_range(1, 4), 16'(d), 16'(d ^ 1), 1'b0, a, ok);
            tests_run++;
            if (!ok || a !== exp_addr) begin
                tests_failed++;
                $display("FAIL random_addr: got ok=%b addr=%0d, required 1/%0d", ok, a, exp_addr);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_repulse();
        test_data_corners();
        test_stray();
        test_set_wins();
        test_reset_mid();
        test_random();
        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL answers_missing: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
